// File: rtl/iqueue.sv
// iqueue: circular FIFO of decoded instructions feeding the forward stage.
// Optional same-cycle empty bypass: define IQUEUE_BYPASS_EN.
module iqueue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_vec,
    input  logic [2:0]       in_type,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_vec,
    output logic [2:0]       out_type,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_imm,
    output logic [PTR_W:0]   count
);

    if (DEPTH != (1 << PTR_W) || DEPTH < 2) begin : g_bad_cfg
        $error("iqueue: DEPTH must be 2**PTR_W and >= 2");
    end

    typedef struct packed {
        logic        is_vec;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem [DEPTH];
    entry_t           in_e;
    entry_t           hd_e;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   cnt;
    logic             empty;
    logic             byp;
    logic             push;
    logic             pop;

    assign in_e  = '{in_is_vec, in_type, in_rd, in_pc, in_imm};
    assign empty = (cnt == '0);

`ifdef IQUEUE_BYPASS_EN
    // Empty queue forwards the offered entry straight to the head port.
    assign byp = rdy && empty && in_valid && !flush;
`else
    assign byp = 1'b0;
`endif

    assign in_ready  = (cnt != FULL_CNT);
    assign out_valid = !empty || byp;
    assign count     = cnt;

    // A bypassed entry taken in the same cycle never enters storage.
    assign push = in_valid && in_ready && !flush && !(byp && out_ready);
    assign pop  = !empty && out_ready && !flush;

    // Head port: live input on bypass, else the stored head entry.
    always_comb begin
        hd_e = mem[head];
        if (byp) hd_e = in_e;
    end

    assign out_is_vec = hd_e.is_vec;
    assign out_type   = hd_e.typ;
    assign out_rd     = hd_e.rd;
    assign out_pc     = hd_e.pc;
    assign out_imm    = hd_e.imm;

    // Pointer and occupancy state; flush clears, rdy low freezes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (rdy) begin
            if (flush) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                unique case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Entry storage is written at the tail on every accepted push.
    always_ff @(posedge clk) begin
        if (rst && rdy && push) mem[tail] <= in_e;
    end

endmodule

// File: doc/iqueue.md
Name: iqueue

Overview:
- Circular FIFO of decoded instructions between the decoder and the forward stage.
- Each entry holds is_vec, type, rd, pc and imm.
- Presents the head entry to the forward stage with a valid/ready handshake. The forward stage drops ready while it issues a bubble for a MEM instruction.
- Supports a full flush, used on a redirect or mispredict.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 2.
- PTR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- rdy  input  1  global enable; when low, all state holds
- flush  input  1  discard every entry and any push in the same cycle
- in_valid  input  1  decoder offers an entry
- in_ready  output  1  queue can accept; high when count < DEPTH
- in_is_vec  input  1  vector-instruction flag
- in_type  input  3  instruction class (const.v type codes, e.g. MEM)
- in_rd  input  5  destination register
- in_pc  input  32  instruction pc
- in_imm  input  32  immediate
- out_valid  output  1  head entry is valid; drives the forward stage's ins_rdy input
- out_ready  input  1  forward stage accepts the head
- out_is_vec  output  1  head is_vec
- out_type  output  3  head type
- out_rd  output  5  head rd
- out_pc  output  32  head pc
- out_imm  output  32  head imm
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- State: head and tail pointers (PTR_W bits each, wrap modulo DEPTH), count register, entry storage array.
- Reset (rst==0 at posedge clk): head=0, tail=0, count=0. Consequently out_valid=0, in_ready=1, count=0. Storage contents are don't-care. Reset overrides rdy and flush.
- rdy==0: no pointer, count or storage update; outputs hold.
- push = in_valid && in_ready && !flush
  - Writes the entry at tail; tail <= tail+1.
- pop = out_valid && out_ready && !flush
  - head <= head+1.
- Count update:
  - push and pop together: count unchanged.
  - push only: count+1.
  - pop only: count-1.
- Full (count==DEPTH):
  - in_ready=0; push blocked.
  - A simultaneous pop still frees a slot next cycle. There is no same-cycle push-on-pop when full.
- Empty (count==0):
  - out_valid=0; out_* fields are don't-care.
  - A push becomes visible on out_* the next cycle (1-cycle latency), unless BYPASS is enabled.
- Head outputs: out_valid = (count!=0). out_* are driven combinationally from storage[head] and are stable while out_ready is low.
- Flush:
  - Next cycle: head=tail=0, count=0, out_valid=0.
  - Any push or pop in the flush cycle is ignored.
  - Flush has priority over everything except reset.
- Pointer wrap: tail from DEPTH-1 goes to 0 with no count disturbance. Ordering is strictly FIFO across the wrap.
- Stall: while out_ready==0, the head is not consumed and pushes continue until full.
- Reset mid-operation: all entries are lost; behaves as a flush plus the reset output values.

Optional Feature:
- Macro: IQUEUE_BYPASS_EN.
- Defined, when count==0 and in_valid==1 and flush==0:
  - out_valid=1 and out_* = in_* combinationally in the same cycle.
  - If out_ready is also 1, the entry is consumed directly. It is not written and tail/count are unchanged.
  - If out_ready is 0, it is written normally.
- Undefined: no combinational in-to-out path; minimum latency is 1 cycle.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> count=0, out_valid=0, in_ready=1. After release, push pc=0x100 -> next cycle out_valid=1, out_pc=0x100.
- Fill/drain: push DEPTH entries pc=0x0,0x4,...,0x1C with out_ready=0 -> count=8, in_ready=0. A 9th push is refused. Drain with out_ready=1 -> pcs emerge 0x0..0x1C in order; count=0 afterwards.
- Wrap: push 6, pop 6, push 5 entries imm=1..5, then pop all -> imm order 1,2,3,4,5; head/tail wrap past 7 cleanly.
- Simultaneous push+pop at count=3 -> count stays 3. Popped entry is the oldest; pushed entry lands at the tail.
- Flush: count=5, then flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0. The flushed-cycle push does not appear later.
- rdy gating: count=2, rdy=0 for 3 cycles with in_valid=1 and out_ready=1 -> count stays 2 and out_pc is unchanged. With IQUEUE_BYPASS_EN, on an empty queue push type=MEM with out_ready=1 -> out_valid=1 the same cycle and count stays 0.
